dly_load_seq: RTL and testbench

- Delay-programming sequencer for one or more DDR3 byte lanes.
- Holds a shadow table of every IDELAY/ODELAY tap value per lane.
- On request, replays the whole table to the lanes over the shared dly_data/dly_addr/ld_delay bus, then pulses set so every lane applies its new delays at once.
- Sits between the software/calibration register interface and the PHY byte lanes, in the clk_div domain.

---
 rtl/dly_seq_pkg.sv | 37 +++
 rtl/dly_seq_table.sv | 57 +++++
 rtl/dly_load_seq.sv | 134 +++++++++++++
 tb/tb_dly_load_seq.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dly_seq_pkg.sv
// Shared constants, lane delay address <-> sequence index mapping and FSM states
// for the delay-programming sequencer.
package dly_seq_pkg;

  localparam int unsigned DATA_W       = 8;
  localparam int unsigned ADDR_W       = 5;
  localparam int unsigned DLY_PER_LANE = 19;

  localparam logic [4:0] DQ_ODLY_BASE = 5'd0;
  localparam logic [4:0] DQS_ODLY     = 5'd8;
  localparam logic [4:0] DM_ODLY      = 5'd9;
  localparam logic [4:0] DQ_IDLY_BASE = 5'd16;
  localparam logic [4:0] DQS_IDLY     = 5'd24;
  localparam logic [4:0] K_LAST       = 5'd18;

  typedef enum logic [1:0] {IDLE, LOAD, SET, DONE} seq_state_e;

  // Sequence index 0..18 to lane delay address.
  function automatic logic [4:0] idx_to_addr(input logic [4:0] k);
    if (k <= DM_ODLY)     return DQ_ODLY_BASE + k;
    else if (k < K_LAST)  return k + 5'd6;
    else                  return DQS_IDLY;
  endfunction

  function automatic logic addr_valid(input logic [4:0] a);
    return ((a - DQ_ODLY_BASE) < 5'd8) || (a == DQS_ODLY) || (a == DM_ODLY) ||
           ((a >= DQ_IDLY_BASE) && (a < DQ_IDLY_BASE + 5'd8)) || (a == DQS_IDLY);
  endfunction

  // Only meaningful for addresses that pass addr_valid.
  function automatic logic [4:0] addr_to_idx(input logic [4:0] a);
    if (a <= DM_ODLY)       return a;
    else if (a < DQS_IDLY)  return a - 5'd6;
    else                    return K_LAST;
  endfunction

endpackage

// File: rtl/dly_seq_table.sv
// Shadow delay table: one write port, registered sequencer read port and, with
// DLY_LOAD_SEQ_READBACK_EN defined, a registered readback port.
module dly_seq_table
  import dly_seq_pkg::*;
#(
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned LANE_BITS = 1
) (
  input  logic                 clk_div,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [LANE_BITS-1:0] wr_lane,
  input  logic [4:0]           wr_idx,
  input  logic [7:0]           wr_data,
  input  logic [LANE_BITS-1:0] seq_lane,
  input  logic [4:0]           seq_idx,
  output logic [7:0]           seq_data
`ifdef DLY_LOAD_SEQ_READBACK_EN
  ,
  input  logic [LANE_BITS-1:0] rd_lane,
  input  logic [4:0]           rd_addr,
  output logic [7:0]           rd_data
`endif
);

  localparam int unsigned DEPTH = NUM_LANES * DLY_PER_LANE;
  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [7:0] mem [DEPTH];

  function automatic logic [IDX_W-1:0] flat(input logic [LANE_BITS-1:0] lane,
                                            input logic [4:0] k);
    return IDX_W'(32'(lane) * DLY_PER_LANE + 32'(k));
  endfunction

  // Contents are not reset: the table must survive a mid-replay reset.
  always_ff @(posedge clk_div) begin
    if (wr_en) mem[flat(wr_lane, wr_idx)] <= wr_data;
  end

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) seq_data <= '0;
    else     seq_data <= mem[flat(seq_lane, seq_idx)];
  end

`ifdef DLY_LOAD_SEQ_READBACK_EN
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst)
      rd_data <= '0;
    else if (addr_valid(rd_addr) && (32'(rd_lane) < NUM_LANES))
      rd_data <= mem[flat(rd_lane, addr_to_idx(rd_addr))];
    else
      rd_data <= '0;
  end
`endif

endmodule

// File: rtl/dly_load_seq.sv
// DDR3 byte-lane delay sequencer: replays the shadow table over the shared delay
// bus, then pulses set. Define DLY_LOAD_SEQ_READBACK_EN to add the table readback port.
module dly_load_seq
  import dly_seq_pkg::*;
#(
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned LANE_BITS = 1
) (
  input  logic                 clk_div,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [LANE_BITS-1:0] wr_lane,
  input  logic [4:0]           wr_addr,
  input  logic [7:0]           wr_data,
  output logic                 wr_err,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           dly_data,
  output logic [4:0]           dly_addr,
  output logic [NUM_LANES-1:0] ld_delay,
  output logic [NUM_LANES-1:0] set
`ifdef DLY_LOAD_SEQ_READBACK_EN
  ,
  input  logic [LANE_BITS-1:0] rd_lane,
  input  logic [4:0]           rd_addr,
  output logic [7:0]           rd_data
`endif
);

  seq_state_e           state, state_nxt;
  logic [LANE_BITS-1:0] lane_cnt;
  logic [4:0]           k_cnt;
  logic                 wr_ok_c, issue_c, last_c;
  logic                 s1_vld, s1_last, s2_last;
  logic [LANE_BITS-1:0] s1_lane;
  logic [4:0]           s1_addr;
  logic [7:0]           seq_data;

  assign wr_ok_c = wr_en && (state == IDLE) && addr_valid(wr_addr) &&
                   (32'(wr_lane) < NUM_LANES);

  dly_seq_table #(
    .NUM_LANES (NUM_LANES),
    .LANE_BITS (LANE_BITS)
  ) u_table (
    .clk_div  (clk_div),
    .rst      (rst),
    .wr_en    (wr_ok_c),
    .wr_lane  (wr_lane),
    .wr_idx   (addr_to_idx(wr_addr)),
    .wr_data  (wr_data),
    .seq_lane (lane_cnt),
    .seq_idx  (k_cnt),
    .seq_data (seq_data)
`ifdef DLY_LOAD_SEQ_READBACK_EN
    ,
    .rd_lane  (rd_lane),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
`endif
  );

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // SET waits for the last entry to leave the two-stage read/output pipeline.
  always_comb begin
    state_nxt = state;
    issue_c   = 1'b0;
    last_c    = 1'b0;
    unique case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: begin
        issue_c = 1'b1;
        last_c  = (32'(lane_cnt) == NUM_LANES - 1) && (k_cnt == K_LAST);
        if (last_c) state_nxt = SET;
      end
      SET:  if (s2_last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      lane_cnt <= '0;
      k_cnt    <= '0;
    end else if (issue_c) begin
      if (k_cnt == K_LAST) begin
        k_cnt    <= '0;
        lane_cnt <= last_c ? '0 : lane_cnt + LANE_BITS'(1);
      end else begin
        k_cnt <= k_cnt + 5'd1;
      end
    end
  end

  // Stage 1 aligns with the registered table read; stage 2 is the output bus.
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_last  <= 1'b0;
      s1_lane  <= '0;
      s1_addr  <= '0;
      s2_last  <= 1'b0;
      dly_data <= '0;
      dly_addr <= '0;
      ld_delay <= '0;
      set      <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      s1_vld  <= issue_c;
      s1_last <= last_c;
      s1_lane <= lane_cnt;
      s1_addr <= idx_to_addr(k_cnt);
      s2_last <= s1_vld && s1_last;
      if (s1_vld) begin
        dly_data <= seq_data;
        dly_addr <= s1_addr;
      end
      ld_delay <= s1_vld ? (NUM_LANES'(1) << s1_lane) : '0;
      set      <= ((state == SET) && s2_last) ? '1 : '0;
      done     <= (state == DONE);
      busy     <= (state == LOAD) || (state == SET);
      wr_err   <= wr_en && !wr_ok_c;
    end
  end

endmodule

// File: tb/tb_dly_load_seq.sv
// Scoreboard bench for dly_load_seq (NUM_LANES=2, LANE_BITS=2); covers the
// readback port when DLY_LOAD_SEQ_READBACK_EN is defined.
`timescale 1ns/1ps
module tb_dly_load_seq;

  localparam int unsigned NL = 2;
  localparam int unsigned LB = 2;

  logic          clk_div = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [LB-1:0] wr_lane;
  logic [4:0]    wr_addr;
  logic [7:0]    wr_data;
  logic          wr_err;
  logic          start;
  logic          busy;
  logic          done;
  logic [7:0]    dly_data;
  logic [4:0]    dly_addr;
  logic [NL-1:0] ld_delay;
  logic [NL-1:0] set;
`ifdef DLY_LOAD_SEQ_READBACK_EN
  logic [LB-1:0] rd_lane;
  logic [4:0]    rd_addr;
  logic [7:0]    rd_data;
`endif

  always #5 clk_div = ~clk_div;

  dly_load_seq #(.NUM_LANES(NL), .LANE_BITS(LB)) dut (
    .clk_div  (clk_div),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_lane  (wr_lane),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_err   (wr_err),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .dly_data (dly_data),
    .dly_addr (dly_addr),
    .ld_delay (ld_delay),
    .set      (set)
`ifdef DLY_LOAD_SEQ_READBACK_EN
    ,
    .rd_lane  (rd_lane),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
`endif
  );

  typedef struct packed {
    logic [NL-1:0] ld;
    logic [4:0]    addr;
    logic [7:0]    data;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] model [NL][19];
  int         checks = 0;
  int         errors = 0;

  // Per-replay observations, cycle numbers relative to the start edge T.
  int            n_ld, n_set, set_m, n_done, done_m, busy_first, busy_last, n_wrerr;
  logic [NL-1:0] set_v;

  function automatic logic [4:0] k2a(input int k);
    if (k < 10)      return 5'(k);
    else if (k < 18) return 5'(k + 6);
    else             return 5'd24;
  endfunction

  task automatic do_write(input logic [LB-1:0] l, input logic [4:0] a,
                          input logic [7:0] d, output logic err);
    @(negedge clk_div);
    wr_en = 1'b1; wr_lane = l; wr_addr = a; wr_data = d;
    @(negedge clk_div);
    err   = wr_err;
    wr_en = 1'b0;
  endtask

  // Runs one replay for a fixed 51-cycle window, comparing every ld_delay strobe
  // against the scoreboard and recording timing; optionally injects a start or a write.
  task automatic run_replay(input int start_m, input int wr_m, input logic wr_with_start,
                            input logic [LB-1:0] wl, input logic [4:0] wa, input logic [7:0] wd);
    exp_t e;
    sb_q.delete();
    for (int l = 0; l < NL; l++)
      for (int k = 0; k < 19; k++) begin
        e.ld   = NL'(1) << l;
        e.addr = k2a(k);
        e.data = model[l][k];
        sb_q.push_back(e);
      end
    n_ld = 0; n_set = 0; set_m = -1; n_done = 0; done_m = -1;
    busy_first = -1; busy_last = -1; n_wrerr = 0; set_v = '0;
    @(negedge clk_div);
    start = 1'b1;
    wr_en = wr_with_start; wr_lane = wl; wr_addr = wa; wr_data = wd;
    @(posedge clk_div);
    @(negedge clk_div);
    start = 1'b0;
    for (int m = 0; m <= 50; m++) begin
      if (busy) begin
        if (busy_first < 0) busy_first = m;
        busy_last = m;
      end
      if (ld_delay != '0) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: ld_delay=%b at T+%0d, required no strobe", ld_delay, m);
        end else begin
          e = sb_q.pop_front();
          if (ld_delay !== e.ld || dly_addr !== e.addr || dly_data !== e.data || m != 2 + n_ld) begin
            errors++;
            $display("FAIL sb_entry%0d: got ld=%b addr=%0d data=%h at T+%0d, required ld=%b addr=%0d data=%h at T+%0d",
                     n_ld, ld_delay, dly_addr, dly_data, m, e.ld, e.addr, e.data, 2 + n_ld);
          end
        end
        n_ld++;
      end
      if (set != '0) begin n_set++; set_m = m; set_v = set; end
      if (done)      begin n_done++; done_m = m; end
      if (wr_err)    n_wrerr++;
      start   = (m == start_m);
      wr_en   = (m == wr_m);
      wr_lane = wl; wr_addr = wa; wr_data = wd;
      @(negedge clk_div);
    end
    start = 1'b0;
    wr_en = 1'b0;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_missing: %0d entries never strobed, required 0", sb_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; wr_lane = '0; wr_addr = '0; wr_data = '0; start = 1'b0;
`ifdef DLY_LOAD_SEQ_READBACK_EN
    rd_lane = '0; rd_addr = '0;
`endif
    repeat (3) @(negedge clk_div);
    checks++;
    if ({busy, done, set, ld_delay, dly_data, dly_addr, wr_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b set=%b ld=%b data=%h addr=%h wr_err=%b, required all 0",
               busy, done, set, ld_delay, dly_data, dly_addr, wr_err);
    end
    rst = 1'b0;
    @(negedge clk_div);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b, required 0", busy); end
  endtask

  task automatic test_fill();
    logic err;
    for (int l = 0; l < NL; l++)
      for (int k = 0; k < 19; k++) begin
        model[l][k] = 8'($urandom_range(0, 255));
        if (l == 0 && k == 3)  model[l][k] = 8'h5A;
        if (l == 1 && k == 18) model[l][k] = 8'h17;
        do_write(LB'(l), k2a(k), model[l][k], err);
        checks++;
        if (err !== 1'b0) begin
          errors++;
          $display("FAIL fill_wr_err: lane %0d addr %0d wr_err=%b, required 0", l, k2a(k), err);
        end
      end
  endtask

  task automatic test_replay();
    run_replay(-1, -1, 1'b0, '0, '0, '0);
    checks++;
    if (n_ld != 38) begin errors++; $display("FAIL replay_ld_count: got %0d, required 38", n_ld); end
    checks++;
    if (n_set != 1 || set_m != 40 || set_v !== {NL{1'b1}}) begin
      errors++;
      $display("FAIL replay_set: %0d pulses, last T+%0d value %b, required 1 at T+40 value 11", n_set, set_m, set_v);
    end
    checks++;
    if (n_done != 1 || done_m != 41) begin
      errors++;
      $display("FAIL replay_done: %0d pulses, last T+%0d, required 1 at T+41", n_done, done_m);
    end
    checks++;
    if (busy_first != 1 || busy_last != 40) begin
      errors++;
      $display("FAIL replay_busy: high T+%0d..T+%0d, required T+1..T+40", busy_first, busy_last);
    end
  endtask

  task automatic test_bad_write();
    logic err;
    do_write(2'd0, 5'd12, 8'hFF, err);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL bad_addr12: wr_err=%b, required 1", err); end
    @(negedge clk_div);
    checks++;
    if (wr_err !== 1'b0) begin errors++; $display("FAIL bad_pulse: wr_err=%b, required 0", wr_err); end
    do_write(2'd2, 5'd0, 8'hFF, err);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL bad_lane2: wr_err=%b, required 1", err); end
    do_write(2'd1, 5'd31, 8'hFF, err);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL bad_addr31: wr_err=%b, required 1", err); end
    run_replay(-1, -1, 1'b0, '0, '0, '0);
    checks++;
    if (n_done != 1) begin errors++; $display("FAIL bad_replay_done: got %0d, required 1", n_done); end
  endtask

  task automatic test_busy_collision();
    run_replay(5, 8, 1'b0, 2'd0, 5'd0, 8'hEE);
    checks++;
    if (n_done != 1 || done_m != 41) begin
      errors++;
      $display("FAIL busy_start_ignored: %0d done pulses, last T+%0d, required 1 at T+41", n_done, done_m);
    end
    checks++;
    if (n_wrerr != 1) begin errors++; $display("FAIL busy_wr_err: got %0d pulses, required 1", n_wrerr); end
  endtask

  task automatic test_same_cycle();
    model[1][5] = 8'h33;
    run_replay(-1, -1, 1'b1, 2'd1, 5'd5, 8'h33);
    checks++;
    if (n_wrerr != 0 || n_done != 1) begin
      errors++;
      $display("FAIL same_cycle: wr_err pulses %0d done %0d, required 0 and 1", n_wrerr, n_done);
    end
  endtask

  task automatic test_mid_reset();
    int bad_pulses = 0;
    @(negedge clk_div);
    start = 1'b1;
    @(posedge clk_div);
    @(negedge clk_div);
    start = 1'b0;
    repeat (10) @(negedge clk_div);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: busy=%b at T+10, required 1", busy); end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, set, ld_delay, dly_data, dly_addr, wr_err} !== '0) begin
      errors++;
      $display("FAIL mid_rst_outputs: busy=%b done=%b set=%b ld=%b data=%h addr=%h, required all 0",
               busy, done, set, ld_delay, dly_data, dly_addr);
    end
    repeat (2) @(negedge clk_div);
    rst = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk_div);
      if (set != '0 || done || busy || ld_delay != '0) bad_pulses++;
    end
    checks++;
    if (bad_pulses != 0) begin
      errors++;
      $display("FAIL mid_rst_quiet: %0d cycles with activity, required 0", bad_pulses);
    end
    run_replay(-1, -1, 1'b0, '0, '0, '0);
    checks++;
    if (n_ld != 38 || n_done != 1) begin
      errors++;
      $display("FAIL mid_rst_replay: ld %0d done %0d, required 38 and 1", n_ld, n_done);
    end
  endtask

`ifdef DLY_LOAD_SEQ_READBACK_EN
  task automatic test_readback();
    logic err;
    logic seen_done = 1'b0;
    do_write(2'd1, 5'd17, 8'hC3, err);
    model[1][11] = 8'hC3;
    rd_lane = 2'd1; rd_addr = 5'd17;
    @(negedge clk_div);
    checks++;
    if (rd_data !== 8'hC3) begin errors++; $display("FAIL rb_idle: rd_data=%h, required c3", rd_data); end
    rd_addr = 5'd12;
    @(negedge clk_div);
    checks++;
    if (rd_data !== 8'h00) begin errors++; $display("FAIL rb_invalid: rd_data=%h, required 00", rd_data); end
    start = 1'b1;
    @(posedge clk_div);
    @(negedge clk_div);
    start = 1'b0;
    rd_lane = 2'd1; rd_addr = 5'd17;
    @(negedge clk_div);
    checks++;
    if (rd_data !== 8'hC3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rb_busy: rd_data=%h busy=%b, required c3 and 1", rd_data, busy);
    end
    for (int i = 0; i < 60 && !seen_done; i++) begin
      @(negedge clk_div);
      if (done) seen_done = 1'b1;
    end
    checks++;
    if (!seen_done) begin errors++; $display("FAIL rb_done_timeout: no done within 60 cycles, required done"); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_replay();
    test_bad_write();
    test_busy_collision();
    test_same_cycle();
    test_mid_reset();
`ifdef DLY_LOAD_SEQ_READBACK_EN
    test_readback();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
